alu_cmd_parser: RTL and testbench
=================================

Name: alu_cmd_parser

Overview:
- Upstream stage of alu32 in the UART-ALU datapath.
- Consumes the byte stream from the UART receiver over a valid/ready interface.
- Frames each fixed-format command packet and presents one opcode plus two signed 32-bit operands to alu32 over a valid/ready handshake.
- Malformed packets are discarded byte-accurately so that framing resynchronises on the next packet.

Parameters:
- PacketLen, 16'd12: required value of the length field; total packet bytes including the 4-byte header.
- OpAddByte, 8'h10: header code for Add.
- OpMulByte, 8'h11: header code for Multiply.
- OpDivByte, 8'h12: header code for Divide.

Ports:
- clk_i  in  1  clock; all logic on posedge.
- reset_i  in  1  synchronous reset, active-high (one clock; reset is synchronous and active-high).
- rx_data_i  in  8  byte from UART RX.
- rx_valid_i  in  1  rx_data_i valid.
- rx_ready_o  out  1  parser accepts a byte this cycle.
- valid_o  out  1  command valid toward alu32.
- ready_i  in  1  alu32 ready.
- opcode_o  out  2  alu opcode: Nop=0, Add=1, Multiply=2, Divide=3.
- operand_a_o  out  32  signed operand A.
- operand_b_o  out  32  signed operand B.
- err_o  out  1  one-cycle pulse when a packet is rejected.

Behaviour:
- Packet format:
  - byte0: opcode code.
  - byte1: reserved, ignored.
  - byte2: length LSB.
  - byte3: length MSB.
  - bytes 4-7: A, little-endian.
  - bytes 8-11: B, little-endian.
- A byte transfers when rx_valid_i && rx_ready_o on a posedge.
- rx_ready_o = 1 in every state except Emit.
- FSM states: Opcode, Reserved, LenLo, LenHi, OperandA, OperandB, Emit, Skip.
- Reset state is Opcode. Reset values: valid_o=0, err_o=0, opcode_o=Nop, operand_a_o=0, operand_b_o=0, rx_ready_o=1. Internal counters are cleared.
- Opcode state: latch the decoded opcode (0x10→1, 0x11→2, 0x12→3, anything else→Nop) plus a bad_op flag. Go to Reserved.
- Reserved → LenLo → LenHi: the 16-bit length is assembled across LenLo and LenHi.
- On accepting the LenHi byte:
  - If !bad_op and len == PacketLen: go to OperandA, byte index = 0.
  - Otherwise: pulse err_o in the following cycle.
    - If len > 4: go to Skip with skip count = len-4.
    - Else: go to Opcode.
- OperandA/OperandB: a 2-bit index places the byte at [8*idx+7 : 8*idx] of the operand register. After index 3, advance to OperandB, then to Emit.
- Emit:
  - valid_o=1 beginning the cycle after the final B byte is accepted. Latency is 1 cycle from last byte to valid_o.
  - opcode_o and operands are stable while valid_o=1.
  - On valid_o && ready_i: valid_o=0 next cycle, go to Opcode.
  - Outputs hold their last values after the handshake.
- Skip: decrement the count per accepted byte. When a byte is accepted at count==1, go to Opcode.
- Backpressure: while in Emit, rx_ready_o=0, so no bytes are lost.
- Idle: rx_valid_i=0 in any state stalls the FSM. No timeout.
- The parser performs no divide-by-zero or overflow checks; operands pass through bit-exact.
- Reset mid-packet discards partial state. The next byte is treated as byte0.
- err_o is never asserted together with valid_o.

Decomposition:
- Shared package alu_pkg:
  - opcode_e enum (Nop, Add, Multiply, Divide).
  - Header byte constants.
  - parser_state_e enum.
  - alu32 and the bench import opcode_e from this package.
- No sub-module needed: single FSM plus a 16-bit skip counter and a 2-bit byte index.
- A separate result serializer downstream of alu32 is a distinct future block.

Test Plan:
- Add packet 10 00 0C 00 05 00 00 00 03 00 00 00 → one cycle after the last byte: valid_o=1, opcode_o=1, A=5, B=3. Handshake with ready_i=1 → valid_o drops next cycle.
- Divide packet 12 00 0C 00 F9 FF FF FF 02 00 00 00 with ready_i held 0 for 5 cycles → valid_o held, outputs stable (opcode 3, A=-7, B=2), rx_ready_o=0 throughout. Release ready_i → accepted.
- Bad opcode 7F 00 06 00 AA BB, then a valid Mul packet with A=0x00010000, B=0x00010000 → err_o single pulse, both junk bytes skipped, then opcode_o=2 with the correct operands.
- Length mismatch 11 00 08 00 + 4 bytes, then a valid Add → err_o pulse, 4 bytes skipped, the following Add decoded correctly. Also send len=2 → err_o pulse, next byte treated as byte0.
- Reset asserted after 6 bytes of a packet → then a full Add packet A=0xFFFFFFFF, B=1 decodes as opcode 1, A=-1, B=1. No spurious valid_o or err_o.
- Random stream of 100 legal packets with random rx_valid_i gaps, fed through alu32 → every result matches the reference model.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the UART-ALU datapath: ALU opcodes, command header codes
// and the command parser state encoding.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } opcode_e;

  localparam logic [15:0] PACKET_LEN  = 16'd12;
  localparam logic [7:0]  OP_ADD_BYTE = 8'h10;
  localparam logic [7:0]  OP_MUL_BYTE = 8'h11;
  localparam logic [7:0]  OP_DIV_BYTE = 8'h12;

  typedef enum logic [2:0] {
    ST_OPCODE    = 3'd0,
    ST_RESERVED  = 3'd1,
    ST_LEN_LO    = 3'd2,
    ST_LEN_HI    = 3'd3,
    ST_OPERAND_A = 3'd4,
    ST_OPERAND_B = 3'd5,
    ST_EMIT      = 3'd6,
    ST_SKIP      = 3'd7
  } parser_state_e;

endpackage

// File: rtl/alu_cmd_parser.sv
// Frames fixed-format command packets from the UART byte stream and hands one
// opcode plus two signed operands to alu32; malformed packets are skipped by length.
//
// Handshakes: a byte moves on rx_valid_i && rx_ready_o at posedge, a command
// moves on valid_o && ready_i at posedge; valid_o never drops without ready_i.
module alu_cmd_parser
  import alu_pkg::*;
#(
  parameter logic [15:0] PacketLen = PACKET_LEN,
  parameter logic [7:0]  OpAddByte = OP_ADD_BYTE,
  parameter logic [7:0]  OpMulByte = OP_MUL_BYTE,
  parameter logic [7:0]  OpDivByte = OP_DIV_BYTE
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [7:0]    rx_data_i,
  input  logic          rx_valid_i,
  output logic          rx_ready_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [1:0]    opcode_o,
  output logic [31:0]   operand_a_o,
  output logic [31:0]   operand_b_o,
  output logic          err_o,
  output parser_state_e state_o
);

  parser_state_e state;
  opcode_e       op_q;
  logic          bad_op;
  logic [7:0]    len_lo;
  logic [15:0]   skip_cnt;
  logic [1:0]    idx;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [15:0]   len_word;

  assign len_word   = {rx_data_i, len_lo};
  assign rx_ready_o = (state != ST_EMIT);
  assign state_o    = state;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= ST_OPCODE;
      valid_o     <= 1'b0;
      err_o       <= 1'b0;
      opcode_o    <= OP_NOP;
      operand_a_o <= '0;
      operand_b_o <= '0;
      op_q        <= OP_NOP;
      bad_op      <= 1'b0;
      len_lo      <= '0;
      skip_cnt    <= '0;
      idx         <= '0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      err_o <= 1'b0;
      if (state == ST_EMIT) begin
        if (ready_i) begin
          valid_o <= 1'b0;
          state   <= ST_OPCODE;
        end
      end else if (rx_valid_i) begin
        case (state)
          ST_OPCODE: begin
            bad_op <= 1'b0;
            if (rx_data_i == OpAddByte)      op_q <= OP_ADD;
            else if (rx_data_i == OpMulByte) op_q <= OP_MUL;
            else if (rx_data_i == OpDivByte) op_q <= OP_DIV;
            else begin
              op_q   <= OP_NOP;
              bad_op <= 1'b1;
            end
            state <= ST_RESERVED;
          end
          ST_RESERVED: state <= ST_LEN_LO;
          ST_LEN_LO: begin
            len_lo <= rx_data_i;
            state  <= ST_LEN_HI;
          end
          ST_LEN_HI: begin
            if (!bad_op && len_word == PacketLen) begin
              idx   <= '0;
              state <= ST_OPERAND_A;
            end else begin
              err_o <= 1'b1;
              // The header is already consumed, so only len-4 body bytes remain.
              if (len_word > 16'd4) begin
                skip_cnt <= len_word - 16'd4;
                state    <= ST_SKIP;
              end else begin
                state <= ST_OPCODE;
              end
            end
          end
          ST_OPERAND_A: begin
            a_q[{idx, 3'b000} +: 8] <= rx_data_i;
            idx <= idx + 2'd1;
            if (idx == 2'd3) state <= ST_OPERAND_B;
          end
          ST_OPERAND_B: begin
            b_q[{idx, 3'b000} +: 8] <= rx_data_i;
            idx <= idx + 2'd1;
            // Outputs load only here, so they hold between commands.
            if (idx == 2'd3) begin
              valid_o     <= 1'b1;
              opcode_o    <= op_q;
              operand_a_o <= a_q;
              operand_b_o <= {rx_data_i, b_q[23:0]};
              state       <= ST_EMIT;
            end
          end
          ST_SKIP: begin
            skip_cnt <= skip_cnt - 16'd1;
            if (skip_cnt == 16'd1) state <= ST_OPCODE;
          end
          default: state <= ST_OPCODE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_parser.sv
// Self-checking bench for alu_cmd_parser: directed packets from the test plan
// plus a randomized packet stream scored against a packet-level model.
module tb_alu_cmd_parser;
  import alu_pkg::*;

  localparam int W = 67; // {is_err, opcode[1:0], a[31:0], b[31:0]}

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [7:0]    rx_data_i;
  logic          rx_valid_i;
  logic          rx_ready_o;
  logic          valid_o;
  logic          ready_i;
  logic [1:0]    opcode_o;
  logic [31:0]   operand_a_o;
  logic [31:0]   operand_b_o;
  logic          err_o;
  parser_state_e state_o;

  int n_checks = 0;
  int n_fail   = 0;
  int gap_max  = 0;
  bit ready_rand = 1'b0;
  logic [W-1:0] exp_q[$];

  alu_cmd_parser dut (
    .clk_i(clk_i), .reset_i(reset_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o), .valid_o(valid_o), .ready_i(ready_i), .opcode_o(opcode_o),
    .operand_a_o(operand_a_o), .operand_b_o(operand_b_o), .err_o(err_o), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  task automatic do_reset();
    reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1 reset_i = 1'b0;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Packet-level model: header byte to ALU opcode.
  function automatic logic [1:0] model_op(input logic [7:0] b);
    case (b)
      8'h10:   return 2'd1;
      8'h11:   return 2'd2;
      8'h12:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // ---------------- drivers ----------------
  always @(posedge clk_i) begin
    #1;
    if (ready_rand) ready_i = 1'($urandom_range(0, 1));
  end

  task automatic send_byte(input logic [7:0] b);
    int budget;
    int gap;
    gap = $urandom_range(0, gap_max);
    rx_valid_i = 1'b0;
    repeat (gap) begin
      @(posedge clk_i);
      #1;
    end
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    budget = 0;
    while (!rx_ready_o && budget < 500) begin
      @(posedge clk_i);
      #1;
      budget++;
    end
    if (budget >= 500) fail_now("rx_ready_timeout");
    @(posedge clk_i);
    #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_packet(input logic [7:0] op_byte, input logic [31:0] a, input logic [31:0] b);
    exp_q.push_back({1'b0, model_op(op_byte), a, b});
    send_byte(op_byte);
    send_byte(8'($urandom));
    send_byte(8'h0C);
    send_byte(8'h00);
    send_word(a);
    send_word(b);
  endtask

  task automatic send_bad_header(input logic [7:0] op_byte, input logic [15:0] len);
    exp_q.push_back({1'b1, 66'd0});
    send_byte(op_byte);
    send_byte(8'($urandom));
    send_byte(len[7:0]);
    send_byte(len[15:8]);
  endtask

  task automatic send_junk(input int n);
    for (int i = 0; i < n; i++) send_byte(8'($urandom));
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk_i) begin
    logic [W-1:0] head;
    if (reset_i === 1'b0) begin
      check("err_with_valid", 64'(err_o && valid_o), 64'd0);
      check("rx_ready_vs_emit", 64'(rx_ready_o), 64'(!valid_o));
      if (err_o) begin
        if (exp_q.size() == 0) fail_now("err_unexpected");
        else begin
          head = exp_q.pop_front();
          check("err_expected_kind", 64'(head[66]), 64'd1);
        end
      end
      if (valid_o) begin
        if (exp_q.size() == 0) fail_now("valid_unexpected");
        else begin
          head = exp_q[0];
          check("cmd_expected_kind", 64'(head[66]), 64'd0);
          check("cmd_opcode", 64'(opcode_o), 64'(head[65:64]));
          check("cmd_operand_a", 64'(operand_a_o), 64'(head[63:32]));
          check("cmd_operand_b", 64'(operand_b_o), 64'(head[31:0]));
          if (ready_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int budget;
    logic [7:0]  op_byte;
    logic [15:0] len;
    rx_data_i  = 8'h00;
    rx_valid_i = 1'b0;
    ready_i    = 1'b0;
    do_reset();

    check("reset_valid", 64'(valid_o), 64'd0);
    check("reset_err", 64'(err_o), 64'd0);
    check("reset_opcode", 64'(opcode_o), 64'd0);
    check("reset_a", 64'(operand_a_o), 64'd0);
    check("reset_b", 64'(operand_b_o), 64'd0);
    check("reset_rx_ready", 64'(rx_ready_o), 64'd1);

    // Add 5 + 3, valid exactly one cycle after the last byte, accepted at once.
    ready_i = 1'b1;
    send_packet(8'h10, 32'd5, 32'd3);
    check("add_valid", 64'(valid_o), 64'd1);
    check("add_opcode", 64'(opcode_o), 64'd1);
    check("add_a", 64'(operand_a_o), 64'd5);
    check("add_b", 64'(operand_b_o), 64'd3);
    @(posedge clk_i); #1;
    check("add_valid_drop", 64'(valid_o), 64'd0);

    // Divide -7 / 2 held under backpressure.
    ready_i = 1'b0;
    send_packet(8'h12, 32'hFFFF_FFF9, 32'd2);
    repeat (5) begin
      check("div_hold_valid", 64'(valid_o), 64'd1);
      check("div_hold_rx_ready", 64'(rx_ready_o), 64'd0);
      check("div_hold_opcode", 64'(opcode_o), 64'd3);
      check("div_hold_a", 64'(operand_a_o), 64'hFFFF_FFF9);
      check("div_hold_b", 64'(operand_b_o), 64'd2);
      @(posedge clk_i); #1;
    end
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    check("div_release", 64'(valid_o), 64'd0);
    check("div_hold_after", 64'(operand_a_o), 64'hFFFF_FFF9);

    // Bad opcode with len 6, then Mul 0x10000 * 0x10000.
    send_bad_header(8'h7F, 16'd6);
    check("badop_err_pulse", 64'(err_o), 64'd1);
    send_byte(8'hAA);
    check("badop_err_single", 64'(err_o), 64'd0);
    send_byte(8'hBB);
    send_packet(8'h11, 32'h0001_0000, 32'h0001_0000);
    check("mul_opcode", 64'(opcode_o), 64'd2);
    check("mul_a", 64'(operand_a_o), 64'h0001_0000);

    // Length mismatch (8), then Add; then len 2, then Add.
    send_bad_header(8'h11, 16'd8);
    send_junk(4);
    send_packet(8'h10, 32'h1234_5678, 32'h8765_4321);
    send_bad_header(8'h10, 16'd2);
    send_packet(8'h10, 32'd100, 32'hFFFF_FF00);
    check("len2_resync_a", 64'(operand_a_o), 64'd100);

    // Reset after 6 bytes of a packet discards it.
    send_byte(8'h11); send_byte(8'h00); send_byte(8'h0C);
    send_byte(8'h00); send_byte(8'h44); send_byte(8'h55);
    do_reset();
    check("midreset_valid", 64'(valid_o), 64'd0);
    check("midreset_rx_ready", 64'(rx_ready_o), 64'd1);
    send_packet(8'h10, 32'hFFFF_FFFF, 32'd1);
    check("post_reset_opcode", 64'(opcode_o), 64'd1);
    check("post_reset_a", 64'(operand_a_o), 64'hFFFF_FFFF);
    check("post_reset_b", 64'(operand_b_o), 64'd1);

    // Random stream: 100 legal packets, occasional malformed ones, random gaps/backpressure.
    gap_max    = 3;
    ready_rand = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        op_byte = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'h10 + 8'($urandom_range(0, 2));
        len = 16'($urandom_range(0, 20));
        if (model_op(op_byte) != 2'd0 && len == 16'd12) len = 16'd13;
        send_bad_header(op_byte, len);
        if (len > 16'd4) send_junk(int'(len) - 4);
      end
      op_byte = 8'h10 + 8'($urandom_range(0, 2));
      send_packet(op_byte, $urandom, $urandom);
    end

    budget = 0;
    while (exp_q.size() != 0 && budget < 1000) begin
      @(posedge clk_i); #1;
      budget++;
    end
    ready_rand = 1'b0;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk_i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
